line_fill_unit: RTL and testbench
=================================

// Module: line_fill_unit
// PURPOSE
//  Memory-side refill/write engine below the data cache. On a cache miss it fetches
//  the 4-word (128-bit) line from word-wide main memory, critical word first with
//  wrap-around, and hands the assembled line to the cache data bank.
//  Single-word write-through stores are forwarded to memory.
//  Handshake is level-based: the cache holds rd/wr until ready pulses. The cache
//  stalls the pipeline on ~ready & (rd | wr).
// PARAMETERS
//  MEM_LAT     2   cycles from mem_read/mem_write assertion to data valid/commit (>=1)
//  LINE_WORDS  4   words per line; fixed, from the shared include; not overridable
// PORTS
//  clock       in   1    single clock, rising edge
//  reset       in   1    asynchronous, active-high
//  rd          in   1    line refill request (level, held until ready)
//  wr          in   1    word write request (level, held until ready)
//  addr        in   32   byte address; [31:4] line, [3:2] word, [1:0] ignored
//  wdata       in   32   store data
//  ready       out  1    one-cycle completion pulse
//  busy        out  1    transaction in progress (state != IDLE)
//  word_valid  out  1    one-cycle pulse when the critical (requested) word is captured
//  word_data   out  32   critical word, held stable until the next acceptance
//  line_data   out  128  assembled line, word i in [32*i+31:32*i], held until next accept
//  mem_read    out  1    memory read strobe
//  mem_write   out  1    memory write strobe
//  mem_addr    out  32   word-aligned memory address ([1:0]=0)
//  mem_wdata   out  32   memory write data
//  mem_rdata   in   32   memory read data, valid MEM_LAT cycles after mem_read with stable addr
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-transaction):
//   - State -> IDLE.
//   - All outputs and registers -> 0, including line_data and word_data.
//   - The in-flight transaction is abandoned; memory is left untouched by the aborted read.
//  States and transitions:
//   - IDLE: wr -> WRITE; else rd -> READ; else stay in IDLE.
//   - READ: wait counter wc 0..MEM_LAT-1 and beat counter bc 0..3.
//     mem_read=1, mem_addr={addr[31:4], addr[3:2]+bc (mod 4), 2'b00}.
//     At wc==MEM_LAT-1, mem_rdata is written into line slot (addr[3:2]+bc) mod 4,
//     wc is cleared and bc increments. Beat bc==0 also loads word_data and pulses
//     word_valid on the next cycle. After beat 3 -> DONE.
//   - WRITE: mem_write=1, mem_addr={addr[31:2],2'b00}, mem_wdata=wdata for MEM_LAT cycles,
//     then -> DONE.
//   - DONE: ready=1 for exactly one cycle, then -> IDLE unconditionally.
//  Priority and sampling:
//   - rd and wr both high in IDLE: the write wins; rd is ignored for that transaction.
//   - addr and wdata are captured at acceptance. Changes while busy have no effect.
//   - rd/wr seen while busy or in DONE are not accepted. A request still high in the
//     IDLE cycle after DONE starts a new transaction; the cache drops rd/wr on ready.
//  Latency:
//   - Acceptance edge = cycle 0.
//   - Read: ready in cycle 4*MEM_LAT+1; word_valid in cycle MEM_LAT+1.
//   - Write: ready in cycle MEM_LAT+1.
//  Wrap-around: the beat index is a 2-bit add, so offset 3 fetches words 3,0,1,2.
//  Strobes: mem_read and mem_write are never high together and are 0 in IDLE and DONE.
//  ready is 0 whenever busy=0, except in DONE.
// STRUCTURE
//  Shared include mem_defs.vh holds:
//   - state encodings IDLE/READ/WRITE/DONE (2 bits)
//   - LINE_WORDS=4, WORD_OFF_MSB=3, WORD_OFF_LSB=2
//   - line width 128
//  One sub-module, line_buffer: 4x32 register file with slot write enable, 2-bit slot
//  index and 128-bit parallel output. Async clear on reset.
//  FSM, wait counter and beat counter stay in line_fill_unit.
// TESTING
//  Memory model: 256-word array, MEM_LAT=2, word n = 32'hA000_0000+n.
//  1. rd, addr=0x40 held -> mem_addr 0x40,0x44,0x48,0x4C;
//     line_data={A..13,A..12,A..11,A..10}; word_valid in cycle 3, ready in cycle 9.
//  2. rd, addr=0x4C -> fetch order 0x4C,0x40,0x44,0x48; word_data=A000_0013;
//     line_data identical to test 1.
//  3. wr, addr=0x80, wdata=DEAD_BEEF -> mem_write high for 2 cycles; ready in cycle 3;
//     a following rd of 0x80 returns DEAD_BEEF in slot 0.
//  4. rd and wr together, addr=0x10 -> WRITE path only, no mem_read;
//     then rd held past ready -> new READ starts in the IDLE+1 cycle.
//  5. reset asserted mid-READ (after beat 1) -> same-cycle async: busy=0,
//     line_data=0, mem_read=0; a fresh rd completes normally.
//  6. MEM_LAT=1 build -> read ready in cycle 5, write ready in cycle 2;
//     addr changed while busy has no effect.

Source files
------------

// File: rtl/line_fill_unit_pkg.sv
// Shared types and constants for the line fill unit.
// Line geometry and FSM state encoding live here.
package line_fill_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LINE_WORDS   = 4;
  localparam int WORD_OFF_MSB = 3;
  localparam int WORD_OFF_LSB = 2;
  localparam int LINE_W       = 128;

  typedef logic [1:0] slot_t;

  // Beat index wraps inside the line: 2-bit add.
  function automatic slot_t beat_slot(
    input slot_t off,
    input slot_t bc
  );
    return off + bc;
  endfunction

endpackage

// File: rtl/line_fill_unit_line_buffer.sv
// 4x32 line register file, one slot written per beat.
// Whole line is visible in parallel on the output.
module line_buffer
  import line_fill_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  slot_t             slot,
  input  logic [31:0]       wdata,
  output logic [LINE_W-1:0] line
);

  logic [31:0] slot_q [LINE_WORDS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (we) begin
      slot_q[slot] <= wdata;
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      line[32*i +: 32] = slot_q[i];
    end
  end

endmodule

// File: rtl/line_fill_unit.sv
// Cache line refill and write-through engine.
// Critical-word-first wrapped refill, single-word stores.
module line_fill_unit
  import line_fill_unit_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              busy,
  output logic              word_valid,
  output logic [31:0]       word_data,
  output logic [LINE_W-1:0] line_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WCW =
    (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WCW-1:0] WC_LAST =
    WCW'(MEM_LAT - 1);

  state_e         state;
  logic [WCW-1:0] wc;
  slot_t          bc;
  logic [31:4]    base_q;
  slot_t          off_q;

  logic  beat_end;
  logic  buf_we;
  slot_t buf_slot;
  slot_t next_off;
  logic  unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign beat_end = (wc == WC_LAST);
  assign buf_we   = (state == READ) && beat_end;
  assign buf_slot = beat_slot(off_q, bc);
  assign next_off = beat_slot(off_q, bc + 2'd1);

  line_buffer u_buf (
    .clock (clock),
    .reset (reset),
    .we    (buf_we),
    .slot  (buf_slot),
    .wdata (mem_rdata),
    .line  (line_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wc         <= '0;
      bc         <= '0;
      base_q     <= '0;
      off_q      <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      ready      <= 1'b0;
      word_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          wc <= '0;
          bc <= '0;
          if (wr) begin
            state     <= WRITE;
            busy      <= 1'b1;
            mem_write <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
          end else if (rd) begin
            state    <= READ;
            busy     <= 1'b1;
            mem_read <= 1'b1;
            base_q   <= addr[31:4];
            off_q    <= addr[WORD_OFF_MSB:WORD_OFF_LSB];
            mem_addr <= {addr[31:2], 2'b00};
          end
        end
        READ: begin
          if (beat_end) begin
            wc <= '0;
            bc <= bc + 2'd1;
            // First beat is the word the core is waiting on.
            if (bc == 2'd0) begin
              word_data  <= mem_rdata;
              word_valid <= 1'b1;
            end
            if (bc == 2'd3) begin
              state    <= DONE;
              mem_read <= 1'b0;
              ready    <= 1'b1;
            end else begin
              mem_addr <= {base_q, next_off, 2'b00};
            end
          end else begin
            wc <= wc + WCW'(1);
          end
        end
        WRITE: begin
          if (beat_end) begin
            wc        <= '0;
            state     <= DONE;
            mem_write <= 1'b0;
            ready     <= 1'b1;
          end else begin
            wc <= wc + WCW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit.
// Table vectors, corner sequences and random traffic vs a model.
module tb_line_fill_unit;

  localparam int LAT = 2;
  localparam logic [127:0] L1 = {32'hA000_0013, 32'hA000_0012,
                                 32'hA000_0011, 32'hA000_0010};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic ready, busy, word_valid, mem_read, mem_write;
  logic [31:0] word_data, mem_addr, mem_wdata, mem_rdata;
  logic [127:0] line_data;

  logic rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic ready1, busy1, wv1, mrd1, mwr1;
  logic [31:0] word1, maddr1, mwd1, mrdata1;
  logic [127:0] line1;

  always #5 clock = ~clock;

  line_fill_unit #(.MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .ready(ready), .busy(busy),
    .word_valid(word_valid), .word_data(word_data),
    .line_data(line_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  line_fill_unit #(.MEM_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .rd(rd1), .wr(wr1),
    .addr(addr1), .wdata(wdata1), .ready(ready1), .busy(busy1),
    .word_valid(wv1), .word_data(word1),
    .line_data(line1), .mem_read(mrd1),
    .mem_write(mwr1), .mem_addr(maddr1),
    .mem_wdata(mwd1), .mem_rdata(mrdata1)
  );

  // Memory: data only valid once the address has been held LAT cycles.
  logic [31:0] mem [256];
  logic [31:0] mem1 [256];
  bit mem_init = 1'b0;
  logic [31:0] last_maddr = '0;
  bit last_rd = 1'b0;
  int age_q = 0;
  int streak;

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int n = 0; n < 256; n++) begin
        mem[n]  <= 32'hA000_0000 + 32'(n);
        mem1[n] <= 32'hA000_0000 + 32'(n);
      end
      mem_init <= 1'b1;
    end else begin
      if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
      if (mwr1) mem1[maddr1[9:2]] <= mwd1;
    end
    last_maddr <= mem_addr;
    last_rd    <= mem_read;
    age_q      <= mem_read ? streak : 0;
  end

  always_comb begin
    streak = (mem_read && last_rd && mem_addr == last_maddr)
             ? age_q + 1 : 1;
    mem_rdata = 32'hBAD0_0BAD;
    if (mem_read && streak >= LAT) mem_rdata = mem[mem_addr[9:2]];
    mrdata1 = 32'hBAD1_0BAD;
    if (mrd1) mrdata1 = mem1[maddr1[9:2]];
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic [127:0] last_line = '0;
  logic [31:0] last_word = '0;

  int vectors = 0;
  int miscompares = 0;

  int k, rdy_cyc, wv_cyc, wv_n, nrd, nwr;
  bit got_ready, strobe_bad, wd_bad;
  logic [31:0] first_wr_addr;
  logic [31:0] maddr_q [$];

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_maddr(input logic [31:0] a,
                                            input int j);
    logic [31:0] wi;
    wi = ((a >> 2) + 32'(j)) % 32'd4;
    return (a & 32'hFFFF_FFF0) | (wi << 2);
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [127:0] l;
    int base;
    base = int'((a >> 4) & 32'h3F) * 4;
    l = '0;
    for (int s = 0; s < 4; s++) l[32*s +: 32] = ref_mem[base + s];
    return l;
  endfunction

  task automatic model_update(input logic w, input logic [31:0] a,
                              input logic [31:0] d);
    if (w) ref_mem[a[9:2]] = d;
    else begin
      last_word = ref_mem[a[9:2]];
      last_line = model_line(a);
    end
  endtask

  task automatic run_req(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit scramble);
    @(negedge clock);
    rd = r; wr = w; addr = a; wdata = d;
    k = 0; got_ready = 0; rdy_cyc = 0; wv_cyc = 0; wv_n = 0;
    nrd = 0; nwr = 0; strobe_bad = 0; wd_bad = 0;
    first_wr_addr = '0;
    maddr_q.delete();
    while (!got_ready && k < 100) begin
      @(negedge clock);
      k++;
      if (scramble) begin addr = $urandom; wdata = $urandom; end
      if (mem_read && mem_write) strobe_bad = 1;
      if (!busy && (mem_read || mem_write || ready)) strobe_bad = 1;
      if (mem_read) begin
        nrd++;
        if (maddr_q.size() == 0 || maddr_q[$] != mem_addr)
          maddr_q.push_back(mem_addr);
      end
      if (mem_write) begin
        nwr++;
        if (nwr == 1) first_wr_addr = mem_addr;
        if (mem_wdata != d) wd_bad = 1;
      end
      if (word_valid) begin
        if (wv_n == 0) wv_cyc = k;
        wv_n++;
      end
      if (ready) begin
        got_ready = 1; rdy_cyc = k; rd = 0; wr = 0;
      end
    end
    rd = 0; wr = 0;
  endtask

  task automatic check_model(input string tag, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
    check({tag, "/done"}, 128'(got_ready), 128'(1));
    check({tag, "/strobes"}, 128'(strobe_bad), 128'(0));
    model_update(w, a, d);
    if (w) begin
      check({tag, "/wr_rdy"}, 128'(rdy_cyc), 128'(LAT + 1));
      check({tag, "/wr_cycles"}, 128'(nwr), 128'(LAT));
      check({tag, "/wr_noread"}, 128'(nrd), 128'(0));
      check({tag, "/wr_addr"}, 128'(first_wr_addr), 128'(a & ~32'h3));
      check({tag, "/wr_data"}, 128'(wd_bad), 128'(0));
      check({tag, "/wr_nowv"}, 128'(wv_n), 128'(0));
    end else begin
      check({tag, "/rd_rdy"}, 128'(rdy_cyc), 128'(4 * LAT + 1));
      check({tag, "/rd_wv"}, 128'(wv_cyc), 128'(LAT + 1));
      check({tag, "/rd_wvn"}, 128'(wv_n), 128'(1));
      check({tag, "/rd_cycles"}, 128'(nrd), 128'(4 * LAT));
      check({tag, "/rd_beats"}, 128'(maddr_q.size()), 128'(4));
      for (int j = 0; j < 4 && j < maddr_q.size(); j++)
        check({tag, "/order"}, 128'(maddr_q[j]), 128'(exp_maddr(a, j)));
    end
    check({tag, "/word"}, 128'(word_data), 128'(last_word));
    check({tag, "/line"}, line_data, last_line);
  endtask

  typedef struct {
    logic r, w;
    logic [31:0] a, d;
    int rdy, wv, nrd, nwr;
    logic [31:0] fa, word;
    logic [127:0] line;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 256; n++) ref_mem[n] = 32'hA000_0000 + 32'(n);

    tbl[0] = '{1, 0, 32'h40, 0, 9, 3, 8, 0, 32'h40,
               32'hA000_0010, L1};
    tbl[1] = '{1, 0, 32'h4C, 0, 9, 3, 8, 0, 32'h4C,
               32'hA000_0013, L1};
    tbl[2] = '{0, 1, 32'h80, 32'hDEAD_BEEF, 3, 0, 0, 2, 32'h80,
               32'hA000_0013, L1};
    tbl[3] = '{1, 0, 32'h80, 0, 9, 3, 8, 0, 32'h80, 32'hDEAD_BEEF,
               {32'hA000_0023, 32'hA000_0022,
                32'hA000_0021, 32'hDEAD_BEEF}};
    tbl[4] = '{1, 1, 32'h10, 32'h1234_5678, 3, 0, 0, 2, 32'h10,
               32'hDEAD_BEEF,
               {32'hA000_0023, 32'hA000_0022,
                32'hA000_0021, 32'hDEAD_BEEF}};

    repeat (3) @(negedge clock);
    check("reset/busy", 128'(busy), 0);
    check("reset/ready", 128'(ready), 0);
    check("reset/strobes", 128'({mem_read, mem_write, word_valid}), 0);
    check("reset/mem_addr", 128'(mem_addr), 0);
    check("reset/word", 128'(word_data), 0);
    check("reset/line", line_data, 0);
    check("reset/lat1_busy", 128'(busy1), 0);
    reset = 0;

    for (int i = 0; i < 5; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_req(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1);
      check({t, "/t_rdy"}, 128'(rdy_cyc), 128'(tbl[i].rdy));
      check({t, "/t_wv"}, 128'(wv_cyc), 128'(tbl[i].wv));
      check({t, "/t_nrd"}, 128'(nrd), 128'(tbl[i].nrd));
      check({t, "/t_nwr"}, 128'(nwr), 128'(tbl[i].nwr));
      check({t, "/t_faddr"},
            128'(tbl[i].w ? first_wr_addr : maddr_q[0]),
            128'(tbl[i].fa));
      check({t, "/t_word"}, 128'(word_data), 128'(tbl[i].word));
      check({t, "/t_line"}, line_data, tbl[i].line);
      check_model(t, tbl[i].w, tbl[i].a, tbl[i].d);
    end

    // Request held past ready restarts one cycle after DONE.
    @(negedge clock);
    rd = 1; wr = 0; addr = 32'h10; k = 0;
    while (!ready && k < 100) begin @(negedge clock); k++; end
    check("hold/rdy", 128'(k), 128'(9));
    @(negedge clock); k++;
    check("hold/idle", 128'({busy, mem_read}), 0);
    @(negedge clock); k++;
    check("hold/restart", 128'({busy, mem_read}), 128'(2'b11));
    check("hold/restart_addr", 128'(mem_addr), 128'(32'h10));
    rd = 0;
    while (!ready && k < 100) begin @(negedge clock); k++; end
    check("hold/rdy2", 128'(k), 128'(19));
    model_update(0, 32'h10, 0);
    check("hold/word", 128'(word_data), 128'(last_word));
    check("hold/line", line_data, last_line);

    // Asynchronous reset after beat 1 of a refill.
    @(negedge clock);
    rd = 1; addr = 32'h40; k = 0;
    repeat (5) begin @(negedge clock); k++; end
    check("rst/busy_before", 128'({busy, mem_read}), 128'(2'b11));
    reset = 1;
    #1;
    check("rst/busy", 128'(busy), 0);
    check("rst/mem_read", 128'(mem_read), 0);
    check("rst/line", line_data, 0);
    check("rst/word", 128'(word_data), 0);
    rd = 0;
    @(negedge clock);
    reset = 0;
    last_line = '0; last_word = '0;
    run_req(1, 0, 32'h4C, 0, 1);
    check_model("rst/after", 0, 32'h4C, 0);

    for (int i = 0; i < 40; i++) begin
      logic w, r;
      logic [31:0] a, d;
      w = ($urandom_range(0, 2) == 0);
      r = !w || ($urandom_range(0, 1) == 1);
      a = $urandom; d = $urandom;
      run_req(r, w, a, d, 1);
      check_model($sformatf("rand%0d", i), w, a, d);
    end

    // MEM_LAT=1 instance, address scrambled while busy.
    @(negedge clock);
    rd1 = 1; addr1 = 32'h40; k = 0;
    while (!ready1 && k < 50) begin
      @(negedge clock); k++;
      if (k == 1) addr1 = 32'h80;
    end
    rd1 = 0;
    check("lat1/rd_rdy", 128'(k), 128'(5));
    check("lat1/rd_line", line1, L1);
    check("lat1/rd_word", 128'(word1), 128'(32'hA000_0010));
    @(negedge clock);
    wr1 = 1; addr1 = 32'h44; wdata1 = 32'h5555_AAAA; k = 0;
    while (!ready1 && k < 50) begin
      @(negedge clock); k++;
      if (k == 1) begin addr1 = 32'hC0; wdata1 = 0; end
    end
    wr1 = 0;
    check("lat1/wr_rdy", 128'(k), 128'(2));
    @(negedge clock);
    rd1 = 1; addr1 = 32'h40; k = 0;
    while (!ready1 && k < 50) begin @(negedge clock); k++; end
    rd1 = 0;
    check("lat1/rd2_rdy", 128'(k), 128'(5));
    check("lat1/rd2_line", line1,
          {32'hA000_0013, 32'hA000_0012, 32'h5555_AAAA, 32'hA000_0010});

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
